seg_scan_controller: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It drives one shared `encoder_7segment` instance, presenting one BCD digit at a time and enabling the matching digit anode. A double-buffered digit register keeps frames tear-free, and anti-ghosting blank slots separate digits. Optional leading-zero suppression is provided. It sits between the numeric datapath (load side) and the board display pins.

---
 rtl/seg_scan_controller.sv | 102 ++++++++++
 tb/tb_seg_scan_controller.sv | 130 +++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed 7-segment scan with a double-buffered frame, blank slots and leading-zero blanking
module seg_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lzb,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done,
  output logic                    bcd_err
);
  localparam int W = 4 * NUM_DIGITS;
  localparam int MAXC = DIV > BLANK_CYC ? DIV : BLANK_CYC;
  localparam int CW = $clog2(MAXC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SHOW_END = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] pend_q, pend_d, act_q, act_d;
  logic pv_q, pv_d, err_q, err_d;
  logic [3:0] bcd_q, bcd_d;
  logic [6:0] seg_q;
  logic bad, slot_end, boundary, supp;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) bad = bad | (digits_in[4*i +: 4] > 4'd9);
  end
  assign slot_end = cnt_q == (state_q == SHOW ? SHOW_END : BLANK_END);
  assign boundary = en && state_q == SHOW && slot_end && idx_q == LAST;
  // a digit is blank when it and every more-significant digit are zero
  assign supp = lzb && idx_q != '0 && (act_q >> (4 * idx_q)) == '0;
  assign an_out = (state_q == SHOW && !supp) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  assign frame_done = boundary;
  assign bcd_out = bcd_q;
  assign seg_out = seg_q;
  assign bcd_err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    pend_d = load ? digits_in : pend_q;
    pv_d = pv_q;
    act_d = act_q;
    err_d = err_q | (load & bad);
    if (!en) begin
      state_d = IDLE;
      cnt_d = '0;
      idx_d = '0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      cnt_d = '0;
    end else if (slot_end) begin
      state_d = state_q == BLANK ? SHOW : BLANK;
      cnt_d = '0;
      idx_d = state_q == SHOW ? (idx_q == LAST ? '0 : idx_q + IW'(1)) : idx_q;
    end
    // a load on the boundary cycle bypasses pending and wins
    if (boundary) begin
      act_d = load ? digits_in : pv_q ? pend_q : act_q;
      pv_d = 1'b0;
    end else if (load) begin
      act_d = state_q == IDLE ? digits_in : act_q;
      pv_d = state_q != IDLE;
    end
    bcd_d = state_d == IDLE ? bcd_q : act_d[4*idx_d +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      act_q <= '0;
      pv_q <= 1'b0;
      err_q <= 1'b0;
      bcd_q <= '0;
      seg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      act_q <= act_d;
      pv_q <= pv_d;
      err_q <= err_d;
      bcd_q <= bcd_d;
      seg_q <= seg_in;
    end
  end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: frame-level reference model feeding a per-cycle scoreboard
module tb_seg_scan_controller;
  localparam int N = 4, DV = 4, BC = 2, SLOT = DV + BC, FRAME = N * SLOT;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, lzb = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] bcd_out, an_out;
  logic [6:0] seg_in, seg_out;
  logic frame_done, bcd_err;
  typedef struct {
    logic [3:0] an;
    logic fd;
    logic err;
    logic [6:0] seg;
    bit sc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int c = -1;
  logic [15:0] cur = '0, pend = '0;
  bit pv = 0, err = 0, seg0 = 1;
  function automatic logic [6:0] enc(input logic [3:0] b);
    case (b)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b1111111;
    endcase
  endfunction
  assign seg_in = enc(bcd_out);
  always #5 clk = ~clk;
  seg_scan_controller #(.NUM_DIGITS(N), .DIV(DV), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in), .lzb(lzb),
    .bcd_out(bcd_out), .seg_in(seg_in), .seg_out(seg_out), .an_out(an_out),
    .frame_done(frame_done), .bcd_err(bcd_err)
  );
  task automatic cyc(input bit e, input bit l, input bit z, input bit r, input logic [15:0] d);
    exp_t x;
    int slot, ph;
    en = e; load = l; lzb = z; rst = r; digits_in = d;
    x.an = 4'hF; x.fd = 1'b0; x.err = err; x.seg = 7'd0; x.sc = seg0;
    if (c >= 0) begin
      slot = (c % FRAME) / SLOT;
      ph = c % SLOT;
      if (ph >= BC) begin
        x.seg = enc(cur[4*slot +: 4]);
        x.sc = 1;
        x.an = (z && slot > 0 && (cur >> (4 * slot)) == 16'd0) ? 4'hF : ~(4'b0001 << slot);
      end
      x.fd = e && slot == N - 1 && ph == SLOT - 1;
    end
    q.push_back(x);
    seg0 = r;
    if (r) begin
      c = -1; cur = '0; pend = '0; pv = 0; err = 0;
    end else begin
      if (l) begin
        for (int i = 0; i < N; i++) if (d[4*i +: 4] > 4'd9) err = 1;
        if (c < 0) begin cur = d; pv = 0; end
        else begin pend = d; pv = 1; end
      end
      c = e ? c + 1 : -1;
      if (c > 0 && c % FRAME == 0 && pv) begin cur = pend; pv = 0; end
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (an_out !== x.an) begin errors++; $display("FAIL an_out got %b want %b t=%0t", an_out, x.an, $time); end
      checks++;
      if (frame_done !== x.fd) begin errors++; $display("FAIL frame_done got %b want %b t=%0t", frame_done, x.fd, $time); end
      checks++;
      if (bcd_err !== x.err) begin errors++; $display("FAIL bcd_err got %b want %b t=%0t", bcd_err, x.err, $time); end
      if (x.sc) begin
        checks++;
        if (seg_out !== x.seg) begin errors++; $display("FAIL seg_out got %b want %b t=%0t", seg_out, x.seg, $time); end
      end
    end
  end
  function automatic logic [15:0] rnd_digits();
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 9));
    return v;
  endfunction
  initial begin
    bit z;
    int off;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 16'h1234);
    repeat (FRAME + 10) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 16'h5678);
    repeat (2 * FRAME) cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    repeat (FRAME + 2 * SLOT + 3) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 16'h0070);
    repeat (FRAME + 2) cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 16'h00A0);
    repeat (2 * FRAME) cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 16'h0003);
    repeat (2 * FRAME) cyc(1, 0, 1, 0, 0);
    z = 0;
    off = 0;
    for (int k = 0; k < 1500; k++) begin
      bit e;
      if ($urandom_range(0, 29) == 0) z = !z;
      e = off == 0;
      if (off > 0) off--;
      else if ($urandom_range(0, 149) == 0) off = $urandom_range(1, 6);
      cyc(e, $urandom_range(0, 9) == 0, z, $urandom_range(0, 399) == 0, rnd_digits());
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
